// File: rtl/tag_status_ctrl.sv
// tag_status_ctrl: output-side sequencer of the mode controller.
// After the core produces the tag, either streams it onto the output bus
// (encrypt) or consumes the received tag from the input bus and compares it
// in constant time (decrypt); every transaction ends with one status beat.
// Optional feature macro: STATUS_DO_LAST_EN adds a do_last output that marks
// the status beat.

// status_encoder: maps the verification result onto the 32-bit status header.
module status_encoder (
  input  logic        status_sel,
  output logic [31:0] status_word
);

  // 1110 header on success, 1111 on failure, payload bits always zero
  assign status_word = {3'b111, status_sel, 28'b0};

endmodule

module tag_status_ctrl #(
  parameter int TAG_WORDS = 4
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   start,
  input  logic                   decrypt,
  input  logic [32*TAG_WORDS-1:0] tag_in,
  input  logic                   tag_valid,
  input  logic [31:0]            bdi_data,
  input  logic                   bdi_valid,
  output logic                   bdi_ready,
  output logic [31:0]            do_data,
  output logic                   do_valid,
  input  logic                   do_ready,
  output logic                   status_sel,
  output logic                   busy,
  output logic                   done
`ifdef STATUS_DO_LAST_EN
  ,
  output logic                   do_last
`endif
);

  // A single-word tag still needs a one-bit counter to keep widths legal.
  localparam int CNT_W = (TAG_WORDS > 1) ? $clog2(TAG_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TAG_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_TAG = 3'd1,
    ENC_OUT  = 3'd2,
    DEC_IN   = 3'd3,
    STATUS   = 3'd4
  } state_t;

  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         cnt, cnt_nxt;
  logic                     fail, fail_nxt;
  logic                     mode, mode_nxt;
  logic                     sel_nxt;
  logic                     done_nxt;
  logic [32*TAG_WORDS-1:0]  tag_reg, tag_nxt;
  logic [31:0]              cur_word;
  logic                     word_miss;
  logic                     last_word;
  logic [31:0]              status_word;

  status_encoder u_status_encoder (
    .status_sel  (status_sel),
    .status_word (status_word)
  );

  // Select tag word cnt; word 0 sits in the most significant 32 bits.
  always_comb begin
    cur_word = '0;
    for (int i = 0; i < TAG_WORDS; i++) begin
      if (cnt == CNT_W'(i)) begin
        cur_word = tag_reg[32*(TAG_WORDS-1-i) +: 32];
      end
    end
  end

  // Compare is evaluated every cycle so timing never depends on tag contents.
  assign word_miss = (bdi_data != cur_word);
  assign last_word = (cnt == LAST_CNT);

  // Next-state and register-update decode for the transaction sequencer.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fail_nxt  = fail;
    mode_nxt  = mode;
    sel_nxt   = status_sel;
    done_nxt  = 1'b0;
    tag_nxt   = tag_reg;

    case (state)
      IDLE: begin
        if (start) begin
          mode_nxt  = decrypt;
          cnt_nxt   = '0;
          fail_nxt  = 1'b0;
          sel_nxt   = 1'b0;
          state_nxt = WAIT_TAG;
        end
      end

      WAIT_TAG: begin
        if (tag_valid) begin
          tag_nxt   = tag_in;
          state_nxt = mode ? DEC_IN : ENC_OUT;
        end
      end

      ENC_OUT: begin
        if (do_ready) begin
          if (last_word) begin
            cnt_nxt   = '0;
            state_nxt = STATUS;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end

      DEC_IN: begin
        if (bdi_valid) begin
          // Mismatches only accumulate; all words are consumed regardless.
          fail_nxt = fail | word_miss;
          if (last_word) begin
            cnt_nxt   = '0;
            sel_nxt   = fail | word_miss;
            state_nxt = STATUS;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end

      STATUS: begin
        if (do_ready) begin
          // Wipe the tag as soon as the transaction closes.
          tag_nxt   = '0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      cnt        <= '0;
      fail       <= 1'b0;
      mode       <= 1'b0;
      status_sel <= 1'b0;
      done       <= 1'b0;
      tag_reg    <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      fail       <= fail_nxt;
      mode       <= mode_nxt;
      status_sel <= sel_nxt;
      done       <= done_nxt;
      tag_reg    <= tag_nxt;
    end
  end

  // Handshake outputs decode registered state only, never do_ready/bdi_valid.
  always_comb begin
    busy      = (state != IDLE);
    bdi_ready = (state == DEC_IN);
    do_valid  = (state == ENC_OUT) || (state == STATUS);
    do_data   = '0;
    if (state == ENC_OUT) begin
      do_data = cur_word;
    end else if (state == STATUS) begin
      do_data = status_word;
    end
  end

`ifdef STATUS_DO_LAST_EN
  // The status beat is always the final beat of a transaction.
  always_comb begin
    do_last = (state == STATUS);
  end
`endif

endmodule

// File: tb/tb_tag_status_ctrl.sv
// Scoreboard bench for tag_status_ctrl (TAG_WORDS = 4): stimulus pushes the
// expected beats / results, an independent monitor pops and compares them.
`timescale 1ns/1ps
module tb_tag_status_ctrl;

  localparam int TW   = 4;
  localparam int TB_W = 32*TW;

  logic            clk = 1'b0;
  logic            nrst = 1'b0;
  logic            start = 1'b0;
  logic            decrypt = 1'b0;
  logic [TB_W-1:0] tag_in = '0;
  logic            tag_valid = 1'b0;
  logic [31:0]     bdi_data = '0;
  logic            bdi_valid = 1'b0;
  logic            bdi_ready;
  logic [31:0]     do_data;
  logic            do_valid;
  logic            do_ready = 1'b0;
  logic            status_sel;
  logic            busy;
  logic            done;
`ifdef STATUS_DO_LAST_EN
  logic            do_last;
`endif

  tag_status_ctrl #(.TAG_WORDS(TW)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .start      (start),
    .decrypt    (decrypt),
    .tag_in     (tag_in),
    .tag_valid  (tag_valid),
    .bdi_data   (bdi_data),
    .bdi_valid  (bdi_valid),
    .bdi_ready  (bdi_ready),
    .do_data    (do_data),
    .do_valid   (do_valid),
    .do_ready   (do_ready),
    .status_sel (status_sel),
    .busy       (busy),
    .done       (done)
`ifdef STATUS_DO_LAST_EN
    ,
    .do_last    (do_last)
`endif
  );

  typedef struct {
    logic [31:0] data;
    bit          is_status;
  } beat_t;

  beat_t beat_q[$];
  bit    sel_q[$];
  int    done_q[$];

  int n_checks   = 0;
  int n_fail     = 0;
  int cyc        = 0;
  int n_issued   = 0;
  int n_finished = 0;
  bit stall_mode = 1'b0;

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [TB_W-1:0] rand_tag();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // do_ready driver: constant 1 or random back-pressure
  initial forever begin
    @(posedge clk);
    #1;
    do_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: output beats, stall stability, done-time results
  initial begin
    bit          prev_stall;
    logic [31:0] prev_data;
    beat_t       b;
    int          e;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_hold_valid", 128'(do_valid), 128'(1'b1));
          check("stall_hold_data", 128'(do_data), 128'(prev_data));
        end
        if (!do_valid) begin
          check("idle_do_data_zero", 128'(do_data), 128'(0));
`ifdef STATUS_DO_LAST_EN
          check("idle_do_last_zero", 128'(do_last), 128'(0));
`endif
        end
        if (do_valid && do_ready) begin
          if (beat_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: got %08h expected no beat (t=%0t)", do_data, $time);
          end else begin
            b = beat_q.pop_front();
            check(b.is_status ? "status_beat" : "tag_beat", 128'(do_data), 128'(b.data));
`ifdef STATUS_DO_LAST_EN
            check("do_last", 128'(do_last), 128'(b.is_status));
`endif
            if (b.is_status) n_finished++;
          end
        end
        prev_stall = do_valid && !do_ready;
        prev_data  = do_data;
        if (done) begin
          check("busy_low_at_done", 128'(busy), 128'(0));
          if (sel_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 expected 0 (t=%0t)", $time);
          end else begin
            check("status_sel_at_done", 128'(status_sel), 128'(sel_q.pop_front()));
            e = done_q.pop_front();
            if (e >= 0) check("done_cycle", 128'(cyc), 128'(e));
          end
        end
      end
    end
  end

  // Asynchronous reset: outputs must clear at once, scoreboard is flushed
  task automatic do_reset();
    nrst = 1'b0;
    #1;
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_status_sel", 128'(status_sel), 128'(0));
    check("rst_do_valid", 128'(do_valid), 128'(0));
    check("rst_do_data", 128'(do_data), 128'(0));
    check("rst_bdi_ready", 128'(bdi_ready), 128'(0));
`ifdef STATUS_DO_LAST_EN
    check("rst_do_last", 128'(do_last), 128'(0));
`endif
    beat_q.delete();
    sel_q.delete();
    done_q.delete();
    n_issued = n_finished;
    start = 1'b0;
    tag_valid = 1'b0;
    bdi_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    nrst = 1'b1;
  endtask

  // Issue one transaction and push its expected response from whole-tag rules
  task automatic issue(input bit dec, input logic [TB_W-1:0] tag, input logic [TB_W-1:0] rx,
                       input int tdly, input bit stall, input bit sync);
    int    k;
    int    guard;
    beat_t b;
    bit    bad;
    if (sync) begin
      @(posedge clk);
      #1;
    end
    bad = dec && (rx != tag);
    start = 1'b1;
    decrypt = dec;
    if (!dec) begin
      for (int i = 0; i < TW; i++) begin
        b.data = tag[32*(TW-1-i) +: 32];
        b.is_status = 1'b0;
        beat_q.push_back(b);
      end
    end
    b.data = bad ? 32'hF000_0000 : 32'hE000_0000;
    b.is_status = 1'b1;
    beat_q.push_back(b);
    sel_q.push_back(bad);
    done_q.push_back((!stall && tdly == 0) ? cyc + 3 + TW : -1);
    n_issued++;
    @(posedge clk);
    #1;
    start = 1'b0;
    decrypt = 1'($urandom);
    for (int d = 0; d < tdly; d++) begin
      tag_in = rand_tag();
      @(posedge clk);
      #1;
    end
    tag_valid = 1'b1;
    tag_in = tag;
    @(posedge clk);
    #1;
    tag_valid = 1'b0;
    tag_in = rand_tag();
    if (dec) begin
      k = 0;
      guard = 0;
      while (k < TW && guard < 300) begin
        bdi_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        bdi_data  = bdi_valid ? rx[32*(TW-1-k) +: 32] : $urandom;
        start     = (stall && busy) ? 1'($urandom_range(0, 1)) : 1'b0;
        decrypt   = 1'($urandom);
        @(negedge clk);
        if (bdi_valid && bdi_ready) k++;
        @(posedge clk);
        #1;
        guard++;
      end
      bdi_valid = 1'b0;
      start = 1'b0;
      if (k < TW) begin
        n_checks++;
        n_fail++;
        $display("FAIL bdi_timeout: got %0d words expected %0d", k, TW);
      end
    end
  endtask

  // Wait for the issued transaction to close, poking start while busy
  task automatic wait_txn(input bit stall);
    int guard;
    guard = 0;
    forever begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (n_finished >= n_issued) break;
      if (guard >= 400) begin
        n_checks++;
        n_fail++;
        $display("FAIL txn_timeout: got %0d finished expected %0d", n_finished, n_issued);
        do_reset();
        break;
      end
      guard++;
      if (stall && busy) begin
        start = 1'($urandom_range(0, 1));
        decrypt = 1'($urandom);
      end
    end
  endtask

  initial begin
    logic [TB_W-1:0] t0;
    logic [TB_W-1:0] rx;
    logic [TB_W-1:0] tg;
    int s;
    int w;
    bit dec;
    bit stl;

    t0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    stall_mode = 1'b0;
    #1;
    do_reset();
    repeat (2) @(posedge clk);

    // directed encrypt: four tag beats then E0000000, done at cycle 7
    issue(1'b0, t0, '0, 0, 1'b0, 1'b1);
    wait_txn(1'b0);

    // matching decrypt, started in the very cycle done pulses
    issue(1'b1, t0, t0, 0, 1'b0, 1'b0);
    wait_txn(1'b0);

    // mismatch only in word 0: still constant time, fails
    rx = t0;
    rx[TB_W-1 -: 32] = 32'h0011_2234;
    issue(1'b1, t0, rx, 0, 1'b0, 1'b1);
    wait_txn(1'b0);
    repeat (3) begin
      @(negedge clk);
      check("status_sel_hold", 128'(status_sel), 128'(1'b1));
    end

    // reset while word 2 is on the output bus
    issue(1'b0, t0, '0, 0, 1'b0, 1'b1);
    s = cyc - 2;
    while (cyc < s + 4) begin
      @(posedge clk);
      #1;
    end
    #2;
    do_reset();
    issue(1'b0, ~t0, '0, 0, 1'b0, 1'b1);
    wait_txn(1'b0);

    // randomized transactions with optional back-pressure
    for (int n = 0; n < 40; n++) begin
      stl = 1'($urandom_range(0, 1));
      stall_mode = stl;
      dec = 1'($urandom_range(0, 1));
      tg = rand_tag();
      rx = tg;
      if (dec && $urandom_range(0, 1) == 1) begin
        w = $urandom_range(0, TW - 1);
        rx[32*w +: 32] = rx[32*w +: 32] ^ (32'h1 << $urandom_range(0, 31));
      end
      issue(dec, tg, rx, $urandom_range(0, 2), stl, 1'($urandom_range(0, 1)));
      wait_txn(stl);
    end

    stall_mode = 1'b0;
    repeat (4) @(posedge clk);
    check("queues_drained", 128'(beat_q.size() + sel_q.size() + done_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish by 2ms");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

endmodule
